// File: rtl/llc_rst_flush_seq.sv
// llc_rst_flush_seq: walks every LLC set for a reset sweep or a dirty-writeback flush
module llc_rst_flush_seq #(
  parameter int SETS     = 256,
  parameter int WAYS     = 8,
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_rst,
  input  logic                start_flush,
  input  logic [WAYS-1:0]     dirty_mask,
  input  logic                wb_ready,
  output logic                rd_set_en,
  output logic                lookup_en,
  output logic                update_en,
  output logic [SET_BITS-1:0] cur_set,
  output logic                wb_valid,
  output logic [WAY_BITS-1:0] wb_way,
  output logic                rst_stall,
  output logic                flush_stall,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, RST_WR, RD, LOOKUP, SCAN, UPD, FIN} state_t;
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
  state_t state;
  logic [WAYS-1:0] dirty;
  // sweep sequencer: set walk, per-way writeback scan, wrap through FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_set <= '0;
      wb_way  <= '0;
      dirty   <= '0;
    end else begin
      case (state)
        IDLE:
          if (start_rst) begin
            state   <= RST_WR;
            cur_set <= '0;
          end else if (start_flush) begin
            state   <= RD;
            cur_set <= '0;
          end
        RST_WR:
          if (cur_set == LAST_SET) state <= FIN;
          else cur_set <= cur_set + 1'b1;
        RD: state <= LOOKUP;
        LOOKUP: begin
          dirty  <= dirty_mask;
          wb_way <= '0;
          state  <= SCAN;
        end
        SCAN:
          if (!dirty[wb_way] || wb_ready) begin
            if (wb_way == LAST_WAY) state <= UPD;
            else wb_way <= wb_way + 1'b1;
          end
        UPD:
          if (cur_set == LAST_SET) state <= FIN;
          else begin
            cur_set <= cur_set + 1'b1;
            state   <= RD;
          end
        FIN: begin
          cur_set <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign rd_set_en   = state == RD;
  assign lookup_en   = state == LOOKUP;
  assign update_en   = state == RST_WR || state == UPD;
  assign wb_valid    = state == SCAN && dirty[wb_way];
  assign rst_stall   = state == RST_WR;
  assign flush_stall = state == RD || state == LOOKUP || state == SCAN || state == UPD;
  assign busy        = state != IDLE;
  assign done        = state == FIN;
endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// tb_llc_rst_flush_seq: directed checks of reset sweep, flush, handshake stalls and mid-sweep reset
module tb_llc_rst_flush_seq;
  logic clk = 0;
  logic rst, start_rst, start_flush, wb_ready;
  logic [1:0] dirty_mask;
  logic rd_set_en, lookup_en, update_en, wb_valid, rst_stall, flush_stall, busy, done;
  logic [1:0] cur_set;
  logic [0:0] wb_way;
  logic [1:0] mask_by_set [4];
  logic [2:0] hs_q [$];
  int done_cnt = 0;
  int checks = 0;
  int failures = 0;

  llc_rst_flush_seq #(.SETS(4), .WAYS(2), .SET_BITS(2), .WAY_BITS(1)) dut (
    .clk(clk), .rst(rst), .start_rst(start_rst), .start_flush(start_flush),
    .dirty_mask(dirty_mask), .wb_ready(wb_ready), .rd_set_en(rd_set_en),
    .lookup_en(lookup_en), .update_en(update_en), .cur_set(cur_set),
    .wb_valid(wb_valid), .wb_way(wb_way), .rst_stall(rst_stall),
    .flush_stall(flush_stall), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign dirty_mask = mask_by_set[cur_set];

  always @(posedge clk) begin
    if (!rst && wb_valid && wb_ready) hs_q.push_back({cur_set, wb_way});
    if (!rst && done) done_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_masks(input logic [1:0] m0, m1, m2, m3);
    mask_by_set[0] = m0; mask_by_set[1] = m1; mask_by_set[2] = m2; mask_by_set[3] = m3;
  endtask

  initial begin
    int n, cnt_upd, cnt_rd, cnt_wb, cnt_multi, d0, h0;
    rst = 1; start_rst = 0; start_flush = 0; wb_ready = 0;
    set_masks(0, 0, 0, 0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_set", cur_set, 0);
    chk("rst_strobes", {rd_set_en, lookup_en, update_en, wb_valid, done}, 0);
    chk("rst_stalls", {rst_stall, flush_stall}, 0);
    rst = 0;
    tick();

    // 1: reset sweep
    start_rst = 1; tick(); start_rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_upd", update_en, 1);
      chk("t1_set", cur_set, i);
      chk("t1_stall", {rst_stall, flush_stall}, 2'b10);
      chk("t1_done_early", done, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_stall_fin", rst_stall, 0);
    chk("t1_upd_fin", update_en, 0);
    tick();
    chk("t1_done_once", done, 0);
    chk("t1_idle", busy, 0);

    // 2: clean flush
    set_masks(0, 0, 0, 0); wb_ready = 1;
    start_flush = 1; tick(); start_flush = 0;
    cnt_upd = 0; cnt_rd = 0; cnt_wb = 0; cnt_multi = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_upd += int'(update_en); cnt_rd += int'(rd_set_en); cnt_wb += int'(wb_valid);
      if (int'(rd_set_en) + int'(lookup_en) + int'(update_en) + int'(wb_valid) > 1) cnt_multi++;
      if (!flush_stall || rst_stall) cnt_multi++;
      tick();
    end
    chk("t2_upd", cnt_upd, 4);
    chk("t2_rd", cnt_rd, 4);
    chk("t2_wb", cnt_wb, 0);
    chk("t2_onehot", cnt_multi, 0);
    chk("t2_done", done, 1);
    tick();

    // 3: one dirty way, ready stalled five cycles
    set_masks(0, 0, 2'b10, 0); wb_ready = 0;
    h0 = hs_q.size();
    start_flush = 1; tick(); start_flush = 0;
    for (n = 0; n < 40 && !wb_valid; n++) tick();
    chk("t3_wb_seen", wb_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_v", wb_valid, 1);
      chk("t3_hold_w", wb_way, 1);
      chk("t3_hold_s", cur_set, 2);
      tick();
    end
    wb_ready = 1;
    chk("t3_v6", wb_valid, 1);
    tick();
    chk("t3_wb_drop", wb_valid, 0);
    chk("t3_upd", update_en, 1);
    chk("t3_upd_set", cur_set, 2);
    for (n = 0; n < 40 && !done; n++) tick();
    chk("t3_done", done, 1);
    chk("t3_hs_cnt", hs_q.size() - h0, 1);
    if (hs_q.size() > h0) chk("t3_hs_id", hs_q[h0], {2'd2, 1'b1});
    tick();

    // 4: simultaneous starts, then ignored flush mid-sweep
    set_masks(0, 0, 0, 0);
    d0 = done_cnt;
    start_rst = 1; start_flush = 1; tick(); start_rst = 0; start_flush = 0;
    chk("t4_stalls", {rst_stall, flush_stall}, 2'b10);
    tick();
    start_flush = 1; tick(); start_flush = 0;
    cnt_rd = 0;
    for (n = 0; n < 40 && !done; n++) begin
      cnt_rd += int'(rd_set_en);
      tick();
    end
    chk("t4_done", done, 1);
    for (int k = 0; k < 10; k++) begin
      cnt_rd += int'(rd_set_en);
      tick();
    end
    chk("t4_rd", cnt_rd, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_idle", busy, 0);

    // 5: reset while a writeback is pending
    set_masks(0, 2'b01, 0, 0); wb_ready = 0;
    start_flush = 1; tick(); start_flush = 0;
    for (n = 0; n < 40 && !wb_valid; n++) tick();
    chk("t5_wb_seen", wb_valid, 1);
    chk("t5_wb_set", cur_set, 1);
    d0 = done_cnt;
    rst = 1; tick();
    chk("t5_wb", wb_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_set", cur_set, 0);
    chk("t5_stalls", {rst_stall, flush_stall}, 0);
    chk("t5_done", done, 0);
    rst = 0; tick();
    chk("t5_no_done", done_cnt - d0, 0);
    set_masks(0, 0, 0, 0); wb_ready = 1;
    start_flush = 1; tick(); start_flush = 0;
    chk("t5_restart_rd", rd_set_en, 1);
    chk("t5_restart_set", cur_set, 0);
    chk("t5_restart_stall", flush_stall, 1);
    for (n = 0; n < 40 && !done; n++) tick();
    chk("t5_restart_done", done, 1);
    tick();

    // 6: every way dirty, ready always high
    set_masks(2'b11, 2'b11, 2'b11, 2'b11); wb_ready = 1;
    h0 = hs_q.size();
    start_flush = 1; tick(); start_flush = 0;
    for (n = 0; n < 60 && !done; n++) tick();
    chk("t6_done", done, 1);
    chk("t6_hs_cnt", hs_q.size() - h0, 8);
    for (int i = 0; i < 8 && h0 + i < hs_q.size(); i++)
      chk($sformatf("t6_hs%0d", i), hs_q[h0 + i], i);
    tick();
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
